// File: rtl/p2s_link_scheduler.sv
// p2s_link_scheduler
//   Arbitrates one P2S serial link between NUM_REQ requesters. A round-robin
//   arbiter picks a requester, its frame is snapshotted, and the frame is fed
//   to the P2S block one BIT_WIDTH-bit byte at a time (most-significant byte
//   first) through the P2S start/finish handshake. When the last byte has
//   shifted out, the granted requester receives a one-cycle ack. A stalled
//   handshake aborts the frame and raises a sticky timeout flag.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous reset, active-high
//   req          per-requester frame request (level)
//   frame_data   requester i owns slice i; byte b at [b*BIT_WIDTH +: BIT_WIDTH]
//   ack          one-cycle pulse when requester i's frame is fully shifted
//   grant_id     index of the current / last granted requester
//   busy         high from grant through the ack cycle
//   err_timeout  sticky: a P2S handshake wait exceeded TIMEOUT cycles
//   p2s_start    to P2S.start
//   p2s_par_in   to P2S.par_in
//   p2s_finish   from P2S.finish (1 = idle / done)
module p2s_link_scheduler #(
  parameter int NUM_REQ         = 2,
  parameter int BIT_WIDTH       = 8,
  parameter int BYTES_PER_FRAME = 2,
  parameter int TIMEOUT         = 64
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic [NUM_REQ-1:0]                          req,
  input  logic [NUM_REQ*BYTES_PER_FRAME*BIT_WIDTH-1:0] frame_data,
  output logic [NUM_REQ-1:0]                          ack,
  output logic [$clog2(NUM_REQ)-1:0]                  grant_id,
  output logic                                        busy,
  output logic                                        err_timeout,
  output logic                                        p2s_start,
  output logic [BIT_WIDTH-1:0]                        p2s_par_in,
  input  logic                                        p2s_finish
);

  localparam int IDW     = $clog2(NUM_REQ);
  localparam int FRAME_W = BYTES_PER_FRAME * BIT_WIDTH;
  localparam int BIW     = (BYTES_PER_FRAME > 1) ? $clog2(BYTES_PER_FRAME) : 1;
  localparam int TW      = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]           state_reg;
  logic [IDW-1:0]       rr_ptr_reg;
  logic [IDW-1:0]       grant_id_reg;
  logic [BIW-1:0]       byte_idx_reg;
  logic [TW-1:0]        timer_reg;
  logic [FRAME_W-1:0]   frame_reg;
  logic [NUM_REQ-1:0]   ack_reg;
  logic                 busy_reg;
  logic                 err_reg;
  logic                 start_reg;
  logic [BIT_WIDTH-1:0] par_reg;

  // Per-requester frame slices and per-byte view of the snapshotted frame.
  logic [FRAME_W-1:0]   frame_slice [NUM_REQ];
  logic [BIT_WIDTH-1:0] frame_bytes [BYTES_PER_FRAME];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign frame_slice[gi] = frame_data[gi*FRAME_W +: FRAME_W];
    end
    for (gi = 0; gi < BYTES_PER_FRAME; gi++) begin : g_bytes
      assign frame_bytes[gi] = frame_reg[gi*BIT_WIDTH +: BIT_WIDTH];
    end
  endgenerate

  // Round-robin pick: first set request at or after rr_ptr_reg, wrapping.
  // The loop walks from the farthest candidate back to the pointer so the
  // closest one is the last (winning) assignment.
  logic           any_req;
  logic [IDW-1:0] win_idx;
  logic [IDW-1:0] rr_ptr_next;
  logic [IDW:0]   cand_idx;

  always_comb begin
    any_req  = 1'b0;
    win_idx  = '0;
    cand_idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand_idx = {1'b0, rr_ptr_reg} + (IDW+1)'(k);
      if (cand_idx >= (IDW+1)'(NUM_REQ)) begin
        cand_idx = cand_idx - (IDW+1)'(NUM_REQ);
      end
      if (req[cand_idx[IDW-1:0]]) begin
        any_req = 1'b1;
        win_idx = cand_idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    if (win_idx == IDW'(NUM_REQ - 1)) begin
      rr_ptr_next = '0;
    end else begin
      rr_ptr_next = win_idx + 1'b1;
    end
  end

  logic timer_expired;
  assign timer_expired = (timer_reg == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      rr_ptr_reg   <= '0;
      grant_id_reg <= '0;
      byte_idx_reg <= '0;
      timer_reg    <= '0;
      frame_reg    <= '0;
      ack_reg      <= '0;
      busy_reg     <= 1'b0;
      err_reg      <= 1'b0;
      start_reg    <= 1'b0;
      par_reg      <= '0;
    end else begin
      ack_reg <= '0;
      case (state_reg)
        ST_IDLE: begin
          if (any_req) begin
            grant_id_reg <= win_idx;
            frame_reg    <= frame_slice[win_idx];
            byte_idx_reg <= BIW'(BYTES_PER_FRAME - 1);
            busy_reg     <= 1'b1;
            start_reg    <= 1'b1;
            // Most-significant byte goes first so byte 0 ends nearest the
            // chain input.
            par_reg      <= frame_slice[win_idx][FRAME_W-1 -: BIT_WIDTH];
            rr_ptr_reg   <= rr_ptr_next;
            timer_reg    <= '0;
            state_reg    <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          // P2S acknowledges the start request by dropping finish.
          if (!p2s_finish) begin
            start_reg <= 1'b0;
            timer_reg <= '0;
            state_reg <= ST_SHIFT;
          end else if (timer_expired) begin
            err_reg   <= 1'b1;
            start_reg <= 1'b0;
            busy_reg  <= 1'b0;
            timer_reg <= '0;
            state_reg <= ST_IDLE;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end

        ST_SHIFT: begin
          if (p2s_finish) begin
            timer_reg <= '0;
            if (byte_idx_reg != '0) begin
              byte_idx_reg <= byte_idx_reg - 1'b1;
              par_reg      <= frame_bytes[byte_idx_reg - 1'b1];
              start_reg    <= 1'b1;
              state_reg    <= ST_LOAD;
            end else begin
              // Ack is registered so it is high exactly during DONE.
              ack_reg   <= NUM_REQ'(1) << grant_id_reg;
              state_reg <= ST_DONE;
            end
          end else if (timer_expired) begin
            err_reg   <= 1'b1;
            start_reg <= 1'b0;
            busy_reg  <= 1'b0;
            timer_reg <= '0;
            state_reg <= ST_IDLE;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end

        ST_DONE: begin
          // start stays low here, giving P2S a cycle to latch the chain.
          busy_reg  <= 1'b0;
          state_reg <= ST_IDLE;
        end

        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack         = ack_reg;
  assign grant_id    = grant_id_reg;
  assign busy        = busy_reg;
  assign err_timeout = err_reg;
  assign p2s_start   = start_reg;
  assign p2s_par_in  = par_reg;

endmodule

// File: tb/tb_p2s_link_scheduler.sv
// Bench for p2s_link_scheduler: a behavioural P2S shifter, a transaction-level
// model (round-robin pointer, expected byte queue per grant) checked on every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_p2s_link_scheduler;
  localparam int N   = 2;
  localparam int BW  = 8;
  localparam int BPF = 2;
  localparam int TO  = 64;
  localparam int FW  = BPF * BW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*FW-1:0] frame_data = '0;
  logic [N-1:0]    ack;
  logic [0:0]      grant_id;
  logic            busy;
  logic            err_timeout;
  logic            p2s_start;
  logic [BW-1:0]   p2s_par_in;
  logic            p2s_finish;

  always #5 clk = ~clk;

  p2s_link_scheduler #(
    .NUM_REQ(N), .BIT_WIDTH(BW), .BYTES_PER_FRAME(BPF), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .frame_data(frame_data),
    .ack(ack), .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout),
    .p2s_start(p2s_start), .p2s_par_in(p2s_par_in), .p2s_finish(p2s_finish)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural P2S shifter ----------------
  logic          stuck = 1'b0;   // forces finish=1 and ignores start
  logic          p_busy;
  logic [BW-1:0] p_sh, p_col;
  int            p_cnt;
  logic [BW-1:0] obs_q[$];       // bytes that completed on the serial line

  assign p2s_finish = stuck | ~p_busy;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      p_busy <= 1'b0;
      p_sh   <= '0;
      p_col  <= '0;
      p_cnt  <= 0;
      obs_q.delete();
    end else if (!p_busy) begin
      if (p2s_start && !stuck) begin
        p_busy <= 1'b1;
        p_sh   <= p2s_par_in;
        p_col  <= '0;
        p_cnt  <= BW;
      end
    end else begin
      p_sh  <= p_sh << 1;
      p_col <= {p_col[BW-2:0], p_sh[BW-1]};
      p_cnt <= p_cnt - 1;
      if (p_cnt == 1) begin
        p_busy <= 1'b0;
        obs_q.push_back({p_col[BW-2:0], p_sh[BW-1]});
      end
    end
  end

  // ---------------- transaction model + per-cycle compare ----------------
  logic [N-1:0]    req_e;
  logic [N*FW-1:0] frame_e;
  logic            rst_e;
  always @(posedge clk) begin
    req_e   = req;
    frame_e = frame_data;
    rst_e   = rst;
  end

  int            ptr_m = 0;
  int            gid_m = 0;
  int            bytes_seen = 0;
  logic          err_m = 1'b0;
  logic          busy_q = 1'b0;
  logic [N-1:0]  ack_q = '0;
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] shifted_log[$];
  logic [N-1:0]  ack_log[$];
  int            grant_log[$];

  always @(negedge clk) begin
    if (rst) begin
      ptr_m  = 0;
      err_m  = 1'b0;
      busy_q = 1'b0;
      ack_q  = '0;
      exp_q.delete();
    end else begin
      check("ack_onehot", 32'($onehot0(ack)), 32'd1);
      if (!busy) check("start_when_idle", 32'(p2s_start), 32'd0);
      if (!busy_q && req_e != '0 && !rst_e) check("idle_req_granted", 32'(busy), 32'd1);

      if (!busy_q && busy) begin
        int w;
        w = -1;
        for (int k = 0; k < N; k++) begin
          int i;
          i = (ptr_m + k) % N;
          if (w < 0 && req_e[i]) w = i;
        end
        check("grant_id", 32'(grant_id), 32'(w));
        if (w < 0) w = 0;
        ptr_m = (w + 1) % N;
        gid_m = w;
        bytes_seen = 0;
        exp_q.delete();
        for (int b = BPF - 1; b >= 0; b--) exp_q.push_back(frame_e[w*FW + b*BW +: BW]);
        grant_log.push_back(w);
      end
      if (busy) check("grant_id_hold", 32'(grant_id), 32'(gid_m));

      while (obs_q.size() > 0) begin
        logic [BW-1:0] ob;
        ob = obs_q.pop_front();
        shifted_log.push_back(ob);
        if (exp_q.size() == 0) begin
          check("unexpected_byte", 32'(ob), 32'hFFFF_FFFF);
        end else begin
          check("serial_byte", 32'(ob), 32'(exp_q.pop_front()));
          bytes_seen++;
        end
      end

      if (ack != '0) begin
        check("ack_id", 32'(ack), 32'(1 << gid_m));
        check("ack_bytes", 32'(bytes_seen), 32'(BPF));
        check("ack_busy", 32'(busy), 32'd1);
        ack_log.push_back(ack);
      end

      if (busy_q && !busy && ack_q == '0) begin
        check("abort_only_when_stalled", 32'(stuck), 32'd1);
        err_m = 1'b1;
        exp_q.delete();
      end
      check("err_timeout", 32'(err_timeout), 32'(err_m));

      busy_q = busy;
      ack_q  = ack;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick(2);
    rst = 1'b0;
    tick(1);
    shifted_log.delete();
    ack_log.delete();
    grant_log.delete();
  endtask

  task automatic wait_busy(input string name);
    int c = 0;
    while (!busy && c < 50) begin @(negedge clk); c++; end
    check(name, 32'(busy), 32'd1);
  endtask

  // Waits for the DUT ack at a negedge, then moves to the next posedge+1 so
  // a caller can drop req before the following arbitration edge.
  task automatic wait_ack(input string name);
    int c = 0;
    @(negedge clk);
    while (ack == '0 && c < 200) begin @(negedge clk); c++; end
    check(name, 32'(ack != '0), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_outputs", 32'({ack, grant_id, err_timeout, p2s_start, p2s_par_in}), 32'd0);

    // T1: single frame A55A from requester 0
    do_reset();
    frame_data = {16'h0000, 16'hA55A};
    req = 2'b01;
    wait_busy("t1_grant");
    check("t1_first_par_in", 32'(p2s_par_in), 32'hA5);
    check("t1_start", 32'(p2s_start), 32'd1);
    wait_ack("t1_ack");
    req = '0;
    tick(2);
    check("t1_busy_low", 32'(busy), 32'd0);
    check("t1_ack_val", 32'(ack_log[0]), 32'h1);
    check("t1_bytes", 32'({shifted_log[0], shifted_log[1]}), 32'hA55A);

    // T2: both requesting, alternation 0,1,0,1
    do_reset();
    frame_data = {16'hABCD, 16'h1234};
    req = 2'b11;
    for (int i = 0; i < 4; i++) wait_ack("t2_ack");
    req = '0;
    tick(3);
    check("t2_ack_order", 32'({ack_log[0], ack_log[1], ack_log[2], ack_log[3]}), 32'b01_10_01_10);
    check("t2_grant_order", 32'({grant_log[0][0], grant_log[1][0], grant_log[2][0], grant_log[3][0]}), 32'b0101);
    check("t2_bytes", 32'({shifted_log[0], shifted_log[1], shifted_log[2], shifted_log[3]}), 32'h1234ABCD);

    // T3: P2S never answers -> timeout after TIMEOUT cycles in LOAD
    do_reset();
    stuck = 1'b1;
    req = 2'b01;
    wait_busy("t3_grant");
    begin
      int c = 0;
      while (!err_timeout && c < 200) begin @(negedge clk); c++; end
      check("t3_timeout_cycles", 32'(c), 32'd64);
    end
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_start", 32'(p2s_start), 32'd0);
    check("t3_no_ack", 32'(ack_log.size()), 32'd0);
    @(posedge clk);
    #1;
    stuck = 1'b0;
    wait_ack("t3_regrant_ack");
    req = '0;
    tick(2);
    check("t3_err_sticky", 32'(err_timeout), 32'd1);
    check("t3_regrant_id", 32'(ack_log[0]), 32'h1);

    // T5 (no reset first: err and pointer are live): reset during byte 1 shift
    frame_data = {16'h0000, 16'h9669};
    req = 2'b01;
    wait_busy("t5_grant");
    begin
      int c = 0;
      while (p2s_start && c < 50) begin @(negedge clk); c++; end
    end
    tick(3);
    rst = 1'b1;
    #1;
    check("t5_rst_outputs", 32'({ack, grant_id, busy, err_timeout, p2s_start, p2s_par_in}), 32'd0);
    req = 2'b10;
    tick(2);
    rst = 1'b0;
    wait_busy("t5_regrant");
    check("t5_grant_id", 32'(grant_id), 32'd1);
    wait_ack("t5_ack");
    req = '0;
    tick(2);

    // T4: drop req and change data right after grant
    do_reset();
    frame_data = {16'h0000, 16'hC33C};
    req = 2'b01;
    wait_busy("t4_grant");
    @(posedge clk);
    @(posedge clk);
    #1;
    req = '0;
    frame_data = {16'h5555, 16'hFFFF};
    wait_ack("t4_ack");
    tick(2);
    check("t4_bytes", 32'({shifted_log[0], shifted_log[1]}), 32'hC33C);
    check("t4_ack_val", 32'(ack_log[0]), 32'h1);

    // T6: requester 1 alone, then both at its ack -> pointer wrapped to 0
    do_reset();
    frame_data = {16'h0F0F, 16'hF0F0};
    req = 2'b10;
    wait_ack("t6_ack1");
    req = 2'b11;
    wait_busy("t6_grant2");
    check("t6_grant_id", 32'(grant_id), 32'd0);
    wait_ack("t6_ack2");
    req = '0;
    tick(2);

    // Random traffic against the model
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) frame_data = $urandom;
      tick(1);
    end
    req = '0;
    tick(80);
    check("rand_drained", 32'(busy), 32'd0);
    check("rand_traffic_seen", 32'(ack_log.size() > 20), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
